// File: rtl/sha3_absorb_buffer.sv
// rtl/sha3_absorb_buffer.sv - SHA-3 rate-block packer/padder with 1/2-deep block buffering; `SHA3_KECCAK_LEGACY_EN adds ILEGACY (0x01 domain byte)
module sha3_absorb_buffer #(
    parameter int NBUF           = 2,
    parameter int MAX_RATE_WORDS = 18
) (
    input  logic                         ICLK,
    input  logic                         IRST,
    input  logic [63:0]                  IDATA,
    input  logic                         IREADY,
    input  logic                         ILAST,
    input  logic [2:0]                   IBYTE_NUM,
    input  logic [1:0]                   IMODE,
`ifdef SHA3_KECCAK_LEGACY_EN
    input  logic                         ILEGACY,
`endif
    output logic                         OBUFFER_FULL,
    output logic [64*MAX_RATE_WORDS-1:0] OBLOCK,
    output logic                         OBLOCK_VALID,
    output logic                         OBLOCK_FIRST,
    output logic                         OBLOCK_LAST,
    output logic [1:0]                   OBLOCK_MODE,
    input  logic                         IBLOCK_READY
);
    localparam int BW = 64 * MAX_RATE_WORDS;
    localparam int CW = $clog2(MAX_RATE_WORDS);

    typedef enum logic {IDLE, FILL} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [1:0]      mode_q;
    logic            first_q;
    logic [BW-1:0]   blk [2];
    logic [1:0]      full;
    logic [1:0]      bfirst;
    logic [1:0]      blast;
    logic [1:0]      bmode [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic            full_q;

    logic [1:0]      cur_mode;
    logic            cur_first;
    logic [CW-1:0]   rate_m1;
    logic            xfer;
    logic            accept;
    logic            complete;
    logic [7:0]      dom;
    logic [63:0]     pad_word;
    logic [BW-1:0]   nb_blk;
    logic [1:0]      full_nx;
    logic            wr_nx;

    assign cur_mode  = (state == IDLE) ? IMODE : mode_q;
    assign cur_first = (state == IDLE) | first_q;

`ifdef SHA3_KECCAK_LEGACY_EN
    logic legacy_q;
    assign dom = (((state == IDLE) ? ILEGACY : legacy_q)) ? 8'h01 : 8'h06;
`else
    assign dom = 8'h06;
`endif

    always_comb begin
        rate_m1 = CW'(8);
        case (cur_mode)
            2'd0:    rate_m1 = CW'(17);
            2'd1:    rate_m1 = CW'(16);
            2'd2:    rate_m1 = CW'(12);
            default: rate_m1 = CW'(8);
        endcase
    end

    // A transfer in the same cycle frees the oldest buffer, which is the one the fill side waits on.
    assign xfer         = full[rd_ptr] & IBLOCK_READY;
    assign OBUFFER_FULL = full_q & ~xfer;
    assign accept       = IREADY & ~OBUFFER_FULL;
    assign complete     = accept & (ILAST | (cnt == rate_m1));

    always_comb begin
        pad_word = IDATA;
        for (int b = 0; b < 8; b++) begin
            if (ILAST) begin
                if (3'(b) == IBYTE_NUM)
                    pad_word[8*b +: 8] = dom;
                else if (3'(b) > IBYTE_NUM)
                    pad_word[8*b +: 8] = 8'h00;
            end
        end
    end

    // Word 0 of a block clears the buffer so that trailing words after padding read as zero.
    always_comb begin
        nb_blk = (cnt == '0) ? '0 : blk[wr_ptr];
        for (int k = 0; k < MAX_RATE_WORDS; k++) begin
            if (CW'(k) == cnt)
                nb_blk[64*k +: 64] = pad_word;
            if (ILAST && (CW'(k) == rate_m1))
                nb_blk[64*k + 63] = 1'b1;
        end
    end

    always_comb begin
        full_nx = full;
        if (xfer)
            full_nx[rd_ptr] = 1'b0;
        if (complete)
            full_nx[wr_ptr] = 1'b1;
        wr_nx = (complete && NBUF == 2) ? ~wr_ptr : wr_ptr;
    end

    always_ff @(posedge ICLK or negedge IRST) begin
        if (!IRST) begin
            state   <= IDLE;
            cnt     <= '0;
            mode_q  <= 2'd0;
            first_q <= 1'b0;
            full    <= 2'b00;
            bfirst  <= 2'b00;
            blast   <= 2'b00;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            full_q  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                blk[i]   <= '0;
                bmode[i] <= 2'd0;
            end
`ifdef SHA3_KECCAK_LEGACY_EN
            legacy_q <= 1'b0;
`endif
        end else begin
            full   <= full_nx;
            full_q <= full_nx[wr_nx];
            wr_ptr <= wr_nx;
            if (xfer && NBUF == 2)
                rd_ptr <= ~rd_ptr;
            if (accept) begin
                blk[wr_ptr] <= nb_blk;
                if (state == IDLE) begin
                    mode_q <= IMODE;
`ifdef SHA3_KECCAK_LEGACY_EN
                    legacy_q <= ILEGACY;
`endif
                end
                if (complete) begin
                    cnt            <= '0;
                    first_q        <= 1'b0;
                    bfirst[wr_ptr] <= cur_first;
                    blast[wr_ptr]  <= ILAST;
                    bmode[wr_ptr]  <= cur_mode;
                    state          <= ILAST ? IDLE : FILL;
                end else begin
                    cnt     <= cnt + 1'b1;
                    first_q <= cur_first;
                    state   <= FILL;
                end
            end
        end
    end

    assign OBLOCK       = blk[rd_ptr];
    assign OBLOCK_VALID = full[rd_ptr];
    assign OBLOCK_FIRST = bfirst[rd_ptr];
    assign OBLOCK_LAST  = blast[rd_ptr];
    assign OBLOCK_MODE  = bmode[rd_ptr];
endmodule

// File: tb/tb_sha3_absorb_buffer.sv
// tb/tb_sha3_absorb_buffer.sv - directed-vector bench for sha3_absorb_buffer
module tb_sha3_absorb_buffer;
    localparam int MW = 18;
    localparam int BW = 64 * MW;

    logic          ICLK = 1'b0;
    logic          IRST;
    logic [63:0]   IDATA;
    logic          IREADY;
    logic          ILAST;
    logic [2:0]    IBYTE_NUM;
    logic [1:0]    IMODE;
`ifdef SHA3_KECCAK_LEGACY_EN
    logic          ILEGACY = 1'b0;
`endif
    logic          OBUFFER_FULL;
    logic [BW-1:0] OBLOCK;
    logic          OBLOCK_VALID;
    logic          OBLOCK_FIRST;
    logic          OBLOCK_LAST;
    logic [1:0]    OBLOCK_MODE;
    logic          IBLOCK_READY;

    int checks = 0;
    int errors = 0;

    sha3_absorb_buffer #(.NBUF(2), .MAX_RATE_WORDS(MW)) dut (
        .ICLK(ICLK), .IRST(IRST), .IDATA(IDATA), .IREADY(IREADY), .ILAST(ILAST),
        .IBYTE_NUM(IBYTE_NUM), .IMODE(IMODE),
`ifdef SHA3_KECCAK_LEGACY_EN
        .ILEGACY(ILEGACY),
`endif
        .OBUFFER_FULL(OBUFFER_FULL), .OBLOCK(OBLOCK), .OBLOCK_VALID(OBLOCK_VALID),
        .OBLOCK_FIRST(OBLOCK_FIRST), .OBLOCK_LAST(OBLOCK_LAST), .OBLOCK_MODE(OBLOCK_MODE),
        .IBLOCK_READY(IBLOCK_READY)
    );

    always #5 ICLK = ~ICLK;

    function automatic logic [63:0] dw(input logic [7:0] tag, input int i);
        return {tag, 48'h00_1234_5678_9A, 8'(i)};
    endfunction

    function automatic int first_diff(input logic [BW-1:0] a, input logic [BW-1:0] b);
        for (int k = 0; k < MW; k++)
            if (a[64*k +: 64] !== b[64*k +: 64]) return k;
        return 0;
    endfunction

    task automatic send_word(input logic [63:0] d, input logic last, input logic [2:0] nb,
                             input logic [1:0] m);
        logic acc;
        int   t;
        t = 0;
        IDATA = d; ILAST = last; IBYTE_NUM = nb; IMODE = m; IREADY = 1'b1;
        do begin
            @(negedge ICLK);
            acc = !OBUFFER_FULL;
            @(posedge ICLK); #1;
            t++;
        end while (!acc && t < 60);
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_word timeout: word %h not accepted in 60 cycles", d);
        end
        IREADY = 1'b0; ILAST = 1'b0;
    endtask

    task automatic drain();
        IBLOCK_READY = 1'b1;
        repeat (4) @(posedge ICLK);
        #1 IBLOCK_READY = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (OBUFFER_FULL !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", OBUFFER_FULL); end
        checks++; if (OBLOCK_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", OBLOCK_VALID); end
        checks++; if (OBLOCK !== '0) begin errors++; $display("FAIL reset_block word %0d nonzero", first_diff(OBLOCK, '0)); end
        checks++; if (OBLOCK_FIRST !== 1'b0) begin errors++; $display("FAIL reset_first got %b want 0", OBLOCK_FIRST); end
        checks++; if (OBLOCK_LAST !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", OBLOCK_LAST); end
        checks++; if (OBLOCK_MODE !== 2'd0) begin errors++; $display("FAIL reset_mode got %0d want 0", OBLOCK_MODE); end
    endtask

    task automatic test_empty();
        logic [BW-1:0] exp;
        int k;
        exp = '0;
        exp[63:0]       = 64'h0000_0000_0000_0006;
        exp[64*16 +: 64] = 64'h8000_0000_0000_0000;
        IBLOCK_READY = 1'b0;
        send_word(64'h0, 1'b1, 3'd0, 2'd1);
        checks++; if (OBLOCK_VALID !== 1'b1) begin errors++; $display("FAIL empty_latency valid got %b want 1", OBLOCK_VALID); end
        checks++;
        if (OBLOCK !== exp) begin
            errors++; k = first_diff(OBLOCK, exp);
            $display("FAIL empty_block word %0d got %h want %h", k, OBLOCK[64*k +: 64], exp[64*k +: 64]);
        end
        checks++; if ({OBLOCK_FIRST, OBLOCK_LAST, OBLOCK_MODE} !== 4'b11_01) begin
            errors++; $display("FAIL empty_flags got f=%b l=%b m=%0d want f=1 l=1 m=1", OBLOCK_FIRST, OBLOCK_LAST, OBLOCK_MODE); end
        IBLOCK_READY = 1'b1;
        @(posedge ICLK); #1;
        checks++; if (OBLOCK_VALID !== 1'b0) begin errors++; $display("FAIL empty_xfer valid got %b want 0", OBLOCK_VALID); end
        IBLOCK_READY = 1'b0;
    endtask

    task automatic test_abc(input logic [1:0] m, input int rate);
        logic [BW-1:0] exp;
        int k;
        exp = '0;
        exp[63:0] = 64'h0000_0000_0663_6261;
        exp[64*(rate-1) +: 64] = 64'h8000_0000_0000_0000;
        IBLOCK_READY = 1'b0;
        send_word(64'h0000_0000_0063_6261, 1'b1, 3'd3, m);
        checks++;
        if (OBLOCK !== exp) begin
            errors++; k = first_diff(OBLOCK, exp);
            $display("FAIL abc_block mode %0d word %0d got %h want %h", m, k, OBLOCK[64*k +: 64], exp[64*k +: 64]);
        end
        checks++; if ({OBLOCK_VALID, OBLOCK_FIRST, OBLOCK_LAST, OBLOCK_MODE} !== {3'b111, m}) begin
            errors++; $display("FAIL abc_flags got v=%b f=%b l=%b m=%0d want v=1 f=1 l=1 m=%0d",
                OBLOCK_VALID, OBLOCK_FIRST, OBLOCK_LAST, OBLOCK_MODE, m); end
        drain();
    endtask

    task automatic test_two_blocks();
        logic [BW-1:0] exp1, exp2;
        int k;
        exp1 = '0; exp2 = '0;
        for (int i = 0; i < 9; i++) exp1[64*i +: 64] = dw(8'h31, i);
        exp2[63:0] = 64'h6;
        exp2[64*8 +: 64] = 64'h8000_0000_0000_0000;
        IBLOCK_READY = 1'b0;
        for (int i = 0; i < 9; i++) send_word(dw(8'h31, i), 1'b0, 3'd0, 2'd3);
        checks++;
        if (OBLOCK !== exp1) begin
            errors++; k = first_diff(OBLOCK, exp1);
            $display("FAIL two_blk1 word %0d got %h want %h", k, OBLOCK[64*k +: 64], exp1[64*k +: 64]);
        end
        checks++; if ({OBLOCK_VALID, OBLOCK_FIRST, OBLOCK_LAST, OBLOCK_MODE} !== 5'b110_11) begin
            errors++; $display("FAIL two_blk1_flags got v=%b f=%b l=%b m=%0d want v=1 f=1 l=0 m=3",
                OBLOCK_VALID, OBLOCK_FIRST, OBLOCK_LAST, OBLOCK_MODE); end
        checks++; if (OBUFFER_FULL !== 1'b0) begin errors++; $display("FAIL two_full got %b want 0", OBUFFER_FULL); end
        send_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'd0, 2'd0);
        checks++; if (OBLOCK !== exp1) begin errors++; $display("FAIL two_hold block 1 not held, word0 %h", OBLOCK[63:0]); end
        IBLOCK_READY = 1'b1;
        @(posedge ICLK); #1;
        IBLOCK_READY = 1'b0;
        checks++;
        if (OBLOCK !== exp2) begin
            errors++; k = first_diff(OBLOCK, exp2);
            $display("FAIL two_blk2 word %0d got %h want %h", k, OBLOCK[64*k +: 64], exp2[64*k +: 64]);
        end
        checks++; if ({OBLOCK_VALID, OBLOCK_FIRST, OBLOCK_LAST, OBLOCK_MODE} !== 5'b101_11) begin
            errors++; $display("FAIL two_blk2_flags got v=%b f=%b l=%b m=%0d want v=1 f=0 l=1 m=3",
                OBLOCK_VALID, OBLOCK_FIRST, OBLOCK_LAST, OBLOCK_MODE); end
        drain();
    endtask

    task automatic test_pad86();
        IBLOCK_READY = 1'b0;
        for (int i = 0; i < 8; i++) send_word(dw(8'h42, i), 1'b0, 3'd0, 2'd3);
        send_word(64'h00AA_BBCC_DDEE_FF11, 1'b1, 3'd7, 2'd3);
        checks++; if (OBLOCK[64*8 +: 64] !== 64'h86AA_BBCC_DDEE_FF11) begin
            errors++; $display("FAIL pad86_word8 got %h want 86aabbccddeeff11", OBLOCK[64*8 +: 64]); end
        checks++; if (OBLOCK[64*7 +: 64] !== dw(8'h42, 7)) begin
            errors++; $display("FAIL pad86_word7 got %h want %h", OBLOCK[64*7 +: 64], dw(8'h42, 7)); end
        checks++; if ({OBLOCK_VALID, OBLOCK_FIRST, OBLOCK_LAST} !== 3'b111) begin
            errors++; $display("FAIL pad86_flags got v=%b f=%b l=%b want 111", OBLOCK_VALID, OBLOCK_FIRST, OBLOCK_LAST); end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [BW-1:0] exp [3];
        logic [1:0]    exp_fl [3];
        int n, k;
        for (int b = 0; b < 3; b++) begin
            exp[b] = '0;
            for (int i = 0; i < 9; i++) exp[b][64*i +: 64] = dw(8'hA0 + 8'(b), i);
        end
        exp[2][64*8 +: 64] = 64'h86AA_BBCC_DDEE_FF11;
        exp_fl[0] = 2'b10; exp_fl[1] = 2'b00; exp_fl[2] = 2'b01;
        IBLOCK_READY = 1'b0;
        for (int i = 0; i < 9; i++) send_word(dw(8'hA0, i), 1'b0, 3'd0, 2'd3);
        checks++; if (OBUFFER_FULL !== 1'b0) begin errors++; $display("FAIL bp_full_after_1 got %b want 0", OBUFFER_FULL); end
        for (int i = 0; i < 9; i++) send_word(dw(8'hA1, i), 1'b0, 3'd0, 2'd2);
        checks++; if (OBUFFER_FULL !== 1'b1) begin errors++; $display("FAIL bp_full_after_2 got %b want 1", OBUFFER_FULL); end
        n = 0;
        fork
            begin
                repeat (3) begin
                    @(posedge ICLK); #1;
                    checks++;
                    if (OBLOCK !== exp[0] || OBLOCK_VALID !== 1'b1 || OBUFFER_FULL !== 1'b1) begin
                        errors++; $display("FAIL bp_hold got v=%b full=%b word0 %h want v=1 full=1 word0 %h",
                            OBLOCK_VALID, OBUFFER_FULL, OBLOCK[63:0], exp[0][63:0]);
                    end
                end
                #1 IBLOCK_READY = 1'b1;
            end
            begin
                for (int i = 0; i < 8; i++) send_word(dw(8'hA2, i), 1'b0, 3'd0, 2'd1);
                send_word(64'h00AA_BBCC_DDEE_FF11, 1'b1, 3'd7, 2'd0);
            end
            begin
                for (int c = 0; c < 100 && n < 3; c++) begin
                    @(negedge ICLK);
                    if (OBLOCK_VALID && IBLOCK_READY) begin
                        checks++;
                        if (OBLOCK !== exp[n]) begin
                            errors++; k = first_diff(OBLOCK, exp[n]);
                            $display("FAIL bp_order block %0d word %0d got %h want %h", n, k, OBLOCK[64*k +: 64], exp[n][64*k +: 64]);
                        end
                        checks++;
                        if ({OBLOCK_FIRST, OBLOCK_LAST, OBLOCK_MODE} !== {exp_fl[n], 2'd3}) begin
                            errors++; $display("FAIL bp_flags block %0d got f=%b l=%b m=%0d want fl=%b m=3",
                                n, OBLOCK_FIRST, OBLOCK_LAST, OBLOCK_MODE, exp_fl[n]);
                        end
                        n++;
                    end
                end
            end
        join
        checks++; if (n !== 3) begin errors++; $display("FAIL bp_count got %0d blocks want 3", n); end
        @(posedge ICLK); #1;
        IBLOCK_READY = 1'b0;
    endtask

    task automatic test_reset_mid();
        IBLOCK_READY = 1'b0;
        for (int i = 0; i < 5; i++) send_word(dw(8'h55, i), 1'b0, 3'd0, 2'd0);
        #2 IRST = 1'b0;
        #1;
        checks++; if (OBLOCK !== '0) begin errors++; $display("FAIL rstmid_block word %0d nonzero", first_diff(OBLOCK, '0)); end
        checks++; if ({OBUFFER_FULL, OBLOCK_VALID, OBLOCK_FIRST, OBLOCK_LAST, OBLOCK_MODE} !== 6'b0) begin
            errors++; $display("FAIL rstmid_ctrl got full=%b v=%b f=%b l=%b m=%0d want all 0",
                OBUFFER_FULL, OBLOCK_VALID, OBLOCK_FIRST, OBLOCK_LAST, OBLOCK_MODE); end
        @(posedge ICLK); #1 IRST = 1'b1;
        test_abc(2'd0, 18);
    endtask

    initial begin
        IRST = 1'b0; IDATA = '0; IREADY = 1'b0; ILAST = 1'b0; IBYTE_NUM = '0; IMODE = '0;
        IBLOCK_READY = 1'b0;
        repeat (2) @(posedge ICLK);
        #1;
        test_reset();
        IRST = 1'b1;
        @(posedge ICLK); #1;
        test_empty();
        test_abc(2'd1, 17);
        test_two_blocks();
        test_pad86();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
